// File: rtl/load_store_unit.sv
// load_store_unit
//   RV32I load/store engine between a CPU request port and a 32-bit
//   word-addressed memory with byte-lane enables. It handles any alignment.
//   An access that crosses a word boundary is split into two memory beats.
//   Illegal width codes are answered with an error response and no memory
//   access.
//
// Ports
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   req_valid/ready    request handshake; ready only when idle and out of reset
//   req_we             1 = store, 0 = load
//   req_funct3         RV32I width code (B, H, W, BU, HU)
//   req_addr           byte address
//   req_wdata          store data, right-aligned
//   resp_valid         one-cycle completion pulse
//   resp_rdata         extended load data (0 for stores and errors)
//   resp_err           illegal request flag, qualified by resp_valid
//   mem_wen            memory write enable
//   mem_byte_en        byte-lane enables, lane i = bits [8i+7:8i]
//   mem_addr           word-aligned memory address
//   mem_data           shared bus; driven here only while mem_wen = 1
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_wen,
  output logic [3:0]            mem_byte_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [31:0]           mem_data
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [63:0]           cap_q, cap_d;   // captured load lanes, both beats

  logic                  illegal_req;
  logic [1:0]            offset;
  logic [3:0]            size_mask;
  logic [7:0]            lane_mask;
  logic [31:0]           wdata_sized;
  logic [63:0]           store_bits;
  logic [63:0]           load_shifted;
  logic [31:0]           load_result;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [ADDR_WIDTH-1:0] next_word_addr;
  logic [31:0]           mem_wdata;

  function automatic logic [31:0] lanes_to_bits(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Reserved codes, and unsigned widths on a store, are illegal.
  assign illegal_req = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_we && req_funct3[2]);

  assign offset         = addr_q[1:0];
  assign word_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign next_word_addr = word_addr + ADDR_WIDTH'(4);   // wraps at the top

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    size_mask   = 4'b0000;
    wdata_sized = 32'h0;
    unique case (funct3_q[1:0])
      2'b00:   begin size_mask = 4'b0001; wdata_sized = {24'h0, wdata_q[7:0]};  end
      2'b01:   begin size_mask = 4'b0011; wdata_sized = {16'h0, wdata_q[15:0]}; end
      2'b10:   begin size_mask = 4'b1111; wdata_sized = wdata_q;                end
      default: begin size_mask = 4'b0000; wdata_sized = 32'h0;                  end
    endcase
  end

  // Upper nibble of lane_mask non-zero means the access spills into the next word.
  assign lane_mask  = {4'b0000, size_mask} << offset;
  assign store_bits = {32'h0, wdata_sized} << {offset, 3'b000};

  assign load_shifted = cap_q >> {offset, 3'b000};

  always_comb begin
    load_result = 32'h0;
    unique case (funct3_q)
      3'b000:  load_result = {{24{load_shifted[7]}}, load_shifted[7:0]};
      3'b001:  load_result = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'b010:  load_result = load_shifted[31:0];
      3'b100:  load_result = {24'h0, load_shifted[7:0]};
      3'b101:  load_result = {16'h0, load_shifted[15:0]};
      default: load_result = 32'h0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    cap_d       = cap_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = 32'h0;
    mem_wen     = 1'b0;
    mem_byte_en = 4'b0000;
    mem_addr    = '0;
    mem_wdata   = 32'h0;

    unique case (state_q)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid && req_ready) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = illegal_req;
          cap_d    = 64'h0;
          state_d  = illegal_req ? RESP : ACC0;
        end
      end
      ACC0: begin
        mem_addr    = word_addr;
        mem_byte_en = lane_mask[3:0];
        mem_wen     = we_q;
        mem_wdata   = store_bits[31:0];
        // Memory read path is combinational: the bus holds this beat's data now.
        if (!we_q) cap_d[31:0] = mem_data & lanes_to_bits(lane_mask[3:0]);
        state_d = (lane_mask[7:4] != 4'b0000) ? ACC1 : RESP;
      end
      ACC1: begin
        mem_addr    = next_word_addr;
        mem_byte_en = lane_mask[7:4];
        mem_wen     = we_q;
        mem_wdata   = store_bits[63:32];
        if (!we_q) cap_d[63:32] = mem_data & lanes_to_bits(lane_mask[7:4]);
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? 32'h0 : load_result;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The unit owns the bus only during its own write beats.
  assign mem_data = mem_wen ? mem_wdata : 32'hzzzz_zzzz;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      cap_q    <= 64'h0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      cap_q    <= cap_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-byte combinational-read memory
// model on the shared mem_data bus. Inputs change and outputs are sampled on
// the falling clock edge; the DUT acts on the rising edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wen;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_addr;
  wire  [31:0] mem_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_wen    (mem_wen),
    .mem_byte_en(mem_byte_en),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data)
  );

  // Memory model: bytes reload to known contents while reset is low.
  logic [7:0]  mem [64];
  logic [31:0] rd_word;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
      mem[14] <= 8'h11;
      mem[15] <= 8'h22;
      mem[16] <= 8'h33;
      mem[17] <= 8'h44;
      mem[19] <= 8'h80;
    end else if (mem_wen) begin
      for (int i = 0; i < 4; i++)
        if (mem_byte_en[i]) mem[{mem_addr[5:2], 2'(i)}] <= mem_data[8*i +: 8];
    end
  end

  assign rd_word  = {mem[{mem_addr[5:2], 2'd3}], mem[{mem_addr[5:2], 2'd2}],
                     mem[{mem_addr[5:2], 2'd1}], mem[{mem_addr[5:2], 2'd0}]};
  assign mem_data = mem_wen ? 32'hzzzz_zzzz : rd_word;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Presents a request at a falling edge, lets the rising edge (N) accept it,
  // scrambles the inputs, and returns at the falling edge inside cycle N+1.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    check("ready_at_issue", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFF0;
    req_wdata  = 32'h1234_5678;
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) step();
    check("ready_in_reset", 64'(req_ready), 64'd0);
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    check("reset_mem_wen", 64'(mem_wen), 64'd0);
    check("reset_mem_be", 64'(mem_byte_en), 64'd0);
    check("reset_mem_addr", 64'(mem_addr), 64'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 64'(req_ready), 64'd1);
    step();

    // LB 0x13 -> 0x80 sign-extended, single beat
    issue(1'b0, 3'b000, 32'h13, 32'h0);
    check("lb_b0_addr", 64'(mem_addr), 64'h10);
    check("lb_b0_be", 64'(mem_byte_en), 64'b1000);
    check("lb_b0_wen", 64'(mem_wen), 64'd0);
    check("lb_ready_busy", 64'(req_ready), 64'd0);
    step();
    check("lb_resp_valid", 64'(resp_valid), 64'd1);
    check("lb_rdata", 64'(resp_rdata), 64'hFFFF_FF80);
    check("lb_err", 64'(resp_err), 64'd0);
    step();
    check("lb_resp_pulse", 64'(resp_valid), 64'd0);

    // LBU 0x13 -> zero-extended
    issue(1'b0, 3'b100, 32'h13, 32'h0);
    step();
    check("lbu_resp_valid", 64'(resp_valid), 64'd1);
    check("lbu_rdata", 64'(resp_rdata), 64'h0000_0080);
    step();

    // LW 0x0E -> split over 0x0C / 0x10
    issue(1'b0, 3'b010, 32'h0E, 32'h0);
    check("lw_b0_addr", 64'(mem_addr), 64'h0C);
    check("lw_b0_be", 64'(mem_byte_en), 64'b1100);
    step();
    check("lw_b1_addr", 64'(mem_addr), 64'h10);
    check("lw_b1_be", 64'(mem_byte_en), 64'b0011);
    check("lw_b1_no_resp", 64'(resp_valid), 64'd0);
    step();
    check("lw_resp_valid", 64'(resp_valid), 64'd1);
    check("lw_rdata", 64'(resp_rdata), 64'h4433_2211);
    step();

    // SW 0x10 DEADBEEF
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    check("sw_wen", 64'(mem_wen), 64'd1);
    check("sw_be", 64'(mem_byte_en), 64'b1111);
    check("sw_addr", 64'(mem_addr), 64'h10);
    check("sw_data", 64'(mem_data), 64'hDEAD_BEEF);
    step();
    check("sw_resp_valid", 64'(resp_valid), 64'd1);
    check("sw_err", 64'(resp_err), 64'd0);
    check("sw_rdata_zero", 64'(resp_rdata), 64'd0);
    check("sw_resp_wen", 64'(mem_wen), 64'd0);
    step();

    // LW 0x10 reads the stored word back
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    step();
    check("lw_back_rdata", 64'(resp_rdata), 64'hDEAD_BEEF);
    step();

    // SH 0x13 0xABCD -> split store
    issue(1'b1, 3'b001, 32'h13, 32'h0000_ABCD);
    check("sh_b0_addr", 64'(mem_addr), 64'h10);
    check("sh_b0_be", 64'(mem_byte_en), 64'b1000);
    check("sh_b0_data", 64'(mem_data[31:24]), 64'hCD);
    check("sh_b0_wen", 64'(mem_wen), 64'd1);
    step();
    check("sh_b1_addr", 64'(mem_addr), 64'h14);
    check("sh_b1_be", 64'(mem_byte_en), 64'b0001);
    check("sh_b1_data", 64'(mem_data[7:0]), 64'hAB);
    check("sh_b1_no_resp", 64'(resp_valid), 64'd0);
    step();
    check("sh_resp_valid", 64'(resp_valid), 64'd1);
    step();

    // LH / LHU 0x13 read the split halfword back
    issue(1'b0, 3'b001, 32'h13, 32'h0);
    repeat (2) step();
    check("lh_rdata", 64'(resp_rdata), 64'hFFFF_ABCD);
    step();
    issue(1'b0, 3'b101, 32'h13, 32'h0);
    repeat (2) step();
    check("lhu_rdata", 64'(resp_rdata), 64'h0000_ABCD);
    step();

    // LHU at the top of the address space: beat1 wraps to 0
    issue(1'b0, 3'b101, 32'hFFFF_FFFF, 32'h0);
    check("wrap_b0_addr", 64'(mem_addr), 64'hFFFF_FFFC);
    check("wrap_b0_be", 64'(mem_byte_en), 64'b1000);
    step();
    check("wrap_b1_addr", 64'(mem_addr), 64'h0);
    check("wrap_b1_be", 64'(mem_byte_en), 64'b0001);
    step();
    check("wrap_rdata", 64'(resp_rdata), 64'h0000_003F);
    step();

    // Illegal load funct3=011
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    check("ill_ld_valid", 64'(resp_valid), 64'd1);
    check("ill_ld_err", 64'(resp_err), 64'd1);
    check("ill_ld_rdata", 64'(resp_rdata), 64'd0);
    check("ill_ld_wen", 64'(mem_wen), 64'd0);
    check("ill_ld_be", 64'(mem_byte_en), 64'd0);
    step();
    check("ill_ld_pulse", 64'(resp_valid), 64'd0);
    check("ill_ld_be_after", 64'(mem_byte_en), 64'd0);

    // Illegal store with unsigned width code
    issue(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF);
    check("ill_st_err", 64'(resp_err), 64'd1);
    check("ill_st_wen", 64'(mem_wen), 64'd0);
    step();

    // Reset during ACC0 of a split SH
    issue(1'b1, 3'b001, 32'h13, 32'h0000_1234);
    check("rst_sh_b0_be", 64'(mem_byte_en), 64'b1000);
    rst_n = 1'b0;
    step();
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    check("rst_mem_wen", 64'(mem_wen), 64'd0);
    check("rst_mem_be", 64'(mem_byte_en), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_bus_from_mem", 64'(mem_data), 64'(rd_word));
    step();
    check("rst_no_beat1", 64'(mem_byte_en), 64'd0);
    check("rst_no_resp", 64'(resp_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", 64'(req_ready), 64'd1);
    step();
    check("rst_idle_resp", 64'(resp_valid), 64'd0);

    // Unit is functional again after reset
    issue(1'b0, 3'b100, 32'h13, 32'h0);
    step();
    check("post_rst_lbu", 64'(resp_rdata), 64'h0000_0080);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, giving the byte-address width on both request and memory sides.
REQ-002 SHALL have port clk, input, 1, the only clock; rising-edge triggered.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1, CPU memory request present.
REQ-005 SHALL have port req_ready, output, 1, unit accepts a request this cycle.
REQ-006 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3, RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port req_addr, input, ADDR_WIDTH, byte address, any alignment.
REQ-009 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32, extended load result; 0 for stores and errors.
REQ-012 SHALL have port resp_err, output, 1, illegal request flag, valid with resp_valid.
REQ-013 SHALL have port mem_wen, output, 1, memory write enable.
REQ-014 SHALL have port mem_byte_en, output, 4, lane enables; lane i = bits [8i+7:8i].
REQ-015 SHALL have port mem_addr, output, ADDR_WIDTH, word-aligned address; bits [1:0] always 00.
REQ-016 SHALL have port mem_data, inout, 32, shared bus; the memory drives it whenever mem_wen=0.

Function
REQ-017 SHALL use the FSM states IDLE, ACC0, ACC1, RESP; req_ready=1 only in IDLE with rst_n=1.
REQ-018 SHALL accept on req_valid&req_ready at edge N and register we, funct3, addr and wdata; inputs are ignored outside acceptance.
REQ-019 SHALL flag a request illegal when funct3 is 011/110/111, or when it is a store with funct3[2]=1.
REQ-020 SHALL route an illegal request IDLE->RESP with no memory beat: resp_valid=1, resp_err=1, resp_rdata=0 in cycle N+1.
REQ-021 SHALL compute lanes from size s (1/2/4) and offset o=addr[1:0]: 8-lane mask M=((1<<s)-1)<<o.
REQ-022 SHALL issue beat0 in ACC0 (cycle N+1): mem_addr=addr&~3, mem_byte_en=M[3:0].
REQ-023 SHALL issue beat1 in ACC1 (cycle N+2) only when M[7:4]!=0: mem_addr=(addr&~3)+4, wrapping mod 2^ADDR_WIDTH, mem_byte_en=M[7:4].
REQ-024 SHALL skip ACC1 when M[7:4]=0: ACC0->RESP.
REQ-025 SHALL form stores as 64-bit S=(wdata masked to s bytes)<<(8*o); beat0 drives S[31:0], beat1 drives S[63:32]; mem_wen=1 in each store beat.
REQ-026 SHALL drive mem_data only while mem_wen=1 and hold it high-Z otherwise, so the unit never contends with the memory.
REQ-027 SHALL sample mem_data at the closing edge of each load beat (the memory read path is combinational), capturing enabled lanes only.
REQ-028 SHALL extract the load result from the captured 64-bit value >>(8*o): B/H sign-extended, BU/HU zero-extended, W unmodified.
REQ-029 SHALL pulse resp_valid for exactly one cycle in RESP, then return to IDLE; latency is N+2 unsplit and N+3 split, with no response backpressure.
REQ-030 SHALL hold mem_wen=0, mem_byte_en=0 and mem_addr=0 in IDLE and RESP.

Reset
REQ-031 SHALL, when rst_n=0 at an edge, enter IDLE and drop any in-flight request with no response: next cycle resp_valid=0, resp_err=0, resp_rdata=0, mem_wen=0, mem_byte_en=0, mem_addr=0, mem_data high-Z.
REQ-032 SHALL hold req_ready=0 while rst_n=0; req_ready=1 in the first cycle after rst_n returns high.

Verification
REQ-033 SHALL cover SW addr 0x10, wdata 0xDEADBEEF -> cycle N+1: mem_wen=1, be=1111, addr=0x10, data=0xDEADBEEF; N+2: resp_valid=1, err=0.
REQ-034 SHALL cover byte 0x13=0x80: LB 0x13 -> rdata 0xFFFFFF80 at N+2; LBU 0x13 -> 0x00000080.
REQ-035 SHALL cover SH 0x13, wdata 0x0000ABCD -> N+1: addr 0x10, be=1000, data[31:24]=0xCD; N+2: addr 0x14, be=0001, data[7:0]=0xAB; resp at N+3.
REQ-036 SHALL cover bytes 0x0E..0x11 = 11,22,33,44, LW 0x0E -> beats be=1100 @0x0C and be=0011 @0x10; rdata 0x44332211 at N+3.
REQ-037 SHALL cover funct3=011 load -> resp_err=1 at N+1, mem_wen=0 and be=0 throughout.
REQ-038 SHALL cover rst_n=0 during ACC0 of a split SH -> no beat1, no resp_valid, mem_data high-Z; req_ready=1 after release.
